// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared types and default constants for the register writeback arbiter
// Contents:
//   DEFAULT_*  : default parameter values used by reg_wb_arbiter
//   wb_req_t   : {addr, data} register write record at default widths
//   fsm_t      : arbiter state (NORMAL: WB wins, HOLD: queued LL result wins)
package reg_wb_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_ADDR_WIDTH   = 5;
    localparam int DEFAULT_Q_DEPTH      = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        HOLD   = 1'b1
    } fsm_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO holding long-latency results awaiting a write slot
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   : enqueue one entry (caller guarantees !full)
//   pop               : dequeue the head (caller guarantees !empty)
//   head_data         : current head entry, valid while !empty
//   full, empty       : occupancy flags
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates the full and empty cases when the
    // index bits coincide; DEPTH is a power of two so wrap is natural overflow.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset: entries are only observable between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - shares the register-file write port between pipeline WB and a long-latency unit
// Ports:
//   clk, reset, clk_en                      : clock, sync active-high reset, global enable
//   pipe_wr_en/pipe_w_addr/pipe_w_data      : pipeline writeback request (passes through in the same cycle)
//   pipe_hold                               : registered; WB must stay idle next cycle
//   ll_issue/ll_issue_addr                  : LL op issued, marks its destination busy
//   ll_valid/ll_ready/ll_addr/ll_data       : LL result handshake into the result FIFO
//   sb_rs_addr/sb_rt_addr/sb_rd_addr        : issue-stage scoreboard query
//   sb_stall                                : any queried register has an LL result pending
//   rf_wr_en/rf_w_addr/rf_w_data            : register file write port
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int Q_DEPTH      = DEFAULT_Q_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  pipe_wr_en,
    input  logic [ADDR_WIDTH-1:0] pipe_w_addr,
    input  logic [DATA_WIDTH-1:0] pipe_w_data,
    output logic                  pipe_hold,
    input  logic                  ll_issue,
    input  logic [ADDR_WIDTH-1:0] ll_issue_addr,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [ADDR_WIDTH-1:0] ll_addr,
    input  logic [DATA_WIDTH-1:0] ll_data,
    input  logic [ADDR_WIDTH-1:0] sb_rs_addr,
    input  logic [ADDR_WIDTH-1:0] sb_rt_addr,
    input  logic [ADDR_WIDTH-1:0] sb_rd_addr,
    output logic                  sb_stall,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int CNT_W    = $clog2(STARVE_LIMIT) + 1;

    // Same layout as wb_req_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    fsm_t               state;
    logic [CNT_W-1:0]   starve_cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_eff;

    req_t head;
    req_t push_req;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic active;
    logic head_nz;
    logic ll_write;
    logic starve_inc;

    assign active   = clk_en && !reset;
    assign ll_ready = active && !fifo_full;
    // ll_ready is computed from pre-pop occupancy, so a full FIFO never
    // accepts in the same cycle it pops.
    assign fifo_push = ll_valid && ll_ready;
    assign push_req  = '{addr: ll_addr, data: ll_data};
    assign head_nz   = !fifo_empty && (head.addr != '0);

    wb_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port selection. A head entry aimed at r0 is discarded on sight
    // (even while WB owns the port) so it never holds up younger results.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_w_addr  = '0;
        rf_w_data  = '0;
        fifo_pop   = 1'b0;
        ll_write   = 1'b0;
        starve_inc = 1'b0;
        if (active) begin
            if (state == NORMAL) begin
                if (pipe_wr_en) begin
                    rf_wr_en   = 1'b1;
                    rf_w_addr  = pipe_w_addr;
                    rf_w_data  = pipe_w_data;
                    fifo_pop   = !fifo_empty && !head_nz;
                    starve_inc = head_nz;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ll_write = head_nz;
                end
            end else begin
                // HOLD: any WB request here is a protocol violation and is dropped.
                fifo_pop = !fifo_empty;
                ll_write = head_nz;
            end
            if (ll_write) begin
                rf_wr_en  = 1'b1;
                rf_w_addr = head.addr;
                rf_w_data = head.data;
            end
        end
    end

    // Arbiter FSM with the registered pipe_hold output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else if (clk_en) begin
            case (state)
                NORMAL: begin
                    if (fifo_pop) begin
                        starve_cnt <= '0;
                    end else if (starve_inc) begin
                        starve_cnt <= starve_cnt + 1'b1;
                        if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                            state     <= HOLD;
                            pipe_hold <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state      <= NORMAL;
                    starve_cnt <= '0;
                    pipe_hold  <= 1'b0;
                end
                default: begin
                    state      <= NORMAL;
                    starve_cnt <= '0;
                    pipe_hold  <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard: clear on the LL write first, then set, so a same-cycle
    // issue to the address being retired leaves it busy.
    always_comb begin
        busy_next = busy;
        if (ll_write) begin
            busy_next[head.addr] = 1'b0;
        end
        if (active && ll_issue && (ll_issue_addr != '0)) begin
            busy_next[ll_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else if (clk_en) begin
            busy <= busy_next;
        end
    end

    assign busy_eff = {busy[NUM_REGS-1:1], 1'b0};
    assign sb_stall = busy_eff[sb_rs_addr] | busy_eff[sb_rt_addr] | busy_eff[sb_rd_addr];

    a_no_wb_in_hold: assert property (@(posedge clk) disable iff (reset)
        (clk_en && state == HOLD) |-> !pipe_wr_en);

    a_no_wb_to_busy: assert property (@(posedge clk) disable iff (reset)
        (clk_en && pipe_wr_en && pipe_w_addr != '0) |-> !busy[pipe_w_addr]);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        pipe_wr_en = 1'b0;
    logic [4:0]  pipe_w_addr = '0;
    logic [31:0] pipe_w_data = '0;
    logic        pipe_hold;
    logic        ll_issue = 1'b0;
    logic [4:0]  ll_issue_addr = '0;
    logic        ll_valid = 1'b0;
    logic        ll_ready;
    logic [4:0]  ll_addr = '0;
    logic [31:0] ll_data = '0;
    logic [4:0]  sb_rs_addr = '0;
    logic [4:0]  sb_rt_addr = '0;
    logic [4:0]  sb_rd_addr = '0;
    logic        sb_stall;
    logic        rf_wr_en;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .pipe_wr_en    (pipe_wr_en),
        .pipe_w_addr   (pipe_w_addr),
        .pipe_w_data   (pipe_w_data),
        .pipe_hold     (pipe_hold),
        .ll_issue      (ll_issue),
        .ll_issue_addr (ll_issue_addr),
        .ll_valid      (ll_valid),
        .ll_ready      (ll_ready),
        .ll_addr       (ll_addr),
        .ll_data       (ll_data),
        .sb_rs_addr    (sb_rs_addr),
        .sb_rt_addr    (sb_rt_addr),
        .sb_rd_addr    (sb_rd_addr),
        .sb_stall      (sb_stall),
        .rf_wr_en      (rf_wr_en),
        .rf_w_addr     (rf_w_addr),
        .rf_w_data     (rf_w_data)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change, still well before the next edge.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        pipe_wr_en = 1'b0; pipe_w_addr = '0; pipe_w_data = '0;
        ll_issue = 1'b0; ll_issue_addr = '0;
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        sb_rs_addr = '0; sb_rt_addr = '0; sb_rd_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL reset_rf_wr_en: got %b want 0", rf_wr_en); end
        tests++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL reset_ll_ready: got %b want 0", ll_ready); end
        reset = 1'b0;
        step();
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL idle_rf_wr_en: got %b want 0", rf_wr_en); end
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL idle_ll_ready: got %b want 1", ll_ready); end
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL idle_sb_stall: got %b want 0", sb_stall); end
        tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL idle_pipe_hold: got %b want 0", pipe_hold); end
    endtask

    task automatic test_wb_passthrough();
        pipe_wr_en = 1'b1; pipe_w_addr = 5'd5; pipe_w_data = 32'hDEAD_BEEF;
        settle();
        tests++; if (rf_wr_en !== 1'b1) begin fails++; $display("FAIL wb_en: got %b want 1", rf_wr_en); end
        tests++; if (rf_w_addr !== 5'd5) begin fails++; $display("FAIL wb_addr: got %0d want 5", rf_w_addr); end
        tests++; if (rf_w_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wb_data: got %h want deadbeef", rf_w_data); end
        step();
        pipe_w_addr = 5'd0; pipe_w_data = 32'h0000_0055;
        settle();
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd0) begin fails++; $display("FAIL wb_r0: got en=%b addr=%0d want en=1 addr=0", rf_wr_en, rf_w_addr); end
        step();
        idle_inputs();
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL wb_idle_after: got %b want 0", rf_wr_en); end
    endtask

    task automatic test_scoreboard();
        ll_issue = 1'b1; ll_issue_addr = 5'd9;
        step();
        ll_issue = 1'b0;
        sb_rd_addr = 5'd9;
        settle();
        tests++; if (sb_stall !== 1'b1) begin fails++; $display("FAIL sb_rd_busy: got %b want 1", sb_stall); end
        sb_rd_addr = 5'd0; sb_rs_addr = 5'd9;
        settle();
        tests++; if (sb_stall !== 1'b1) begin fails++; $display("FAIL sb_rs_busy: got %b want 1", sb_stall); end
        sb_rs_addr = 5'd8;
        settle();
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL sb_other_free: got %b want 0", sb_stall); end
        // issue to r0 must not mark anything busy
        ll_issue = 1'b1; ll_issue_addr = 5'd0;
        step();
        ll_issue = 1'b0;
        sb_rs_addr = 5'd0; sb_rt_addr = 5'd0; sb_rd_addr = 5'd0;
        settle();
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL sb_r0_never_busy: got %b want 0", sb_stall); end
        // LL result arrives with pipe idle: no bypass this cycle
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'h0000_1234;
        sb_rd_addr = 5'd9;
        settle();
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL ll_accept_ready: got %b want 1", ll_ready); end
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL ll_no_bypass: got %b want 0", rf_wr_en); end
        step();
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        settle();
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd9 || rf_w_data !== 32'h0000_1234) begin
            fails++; $display("FAIL ll_write: got en=%b addr=%0d data=%h want en=1 addr=9 data=00001234", rf_wr_en, rf_w_addr, rf_w_data);
        end
        tests++; if (sb_stall !== 1'b1) begin fails++; $display("FAIL sb_busy_during_write: got %b want 1", sb_stall); end
        step();
        settle();
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL sb_cleared: got %b want 0", sb_stall); end
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL ll_single_write: got %b want 0", rf_wr_en); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        ll_issue = 1'b1; ll_issue_addr = 5'd7;
        ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'h0000_0077;
        step();
        ll_issue = 1'b0; ll_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pipe_wr_en = 1'b1; pipe_w_addr = 5'd2; pipe_w_data = 32'(i);
            settle();
            tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd2 || pipe_hold !== 1'b0) begin
                fails++; $display("FAIL starve_wb_cycle%0d: got en=%b addr=%0d hold=%b want en=1 addr=2 hold=0", i, rf_wr_en, rf_w_addr, pipe_hold);
            end
            step();
        end
        pipe_wr_en = 1'b0; pipe_w_addr = '0; pipe_w_data = '0;
        sb_rd_addr = 5'd7;
        settle();
        tests++; if (pipe_hold !== 1'b1) begin fails++; $display("FAIL starve_hold: got %b want 1", pipe_hold); end
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd7 || rf_w_data !== 32'h0000_0077) begin
            fails++; $display("FAIL starve_ll_write: got en=%b addr=%0d data=%h want en=1 addr=7 data=00000077", rf_wr_en, rf_w_addr, rf_w_data);
        end
        step();
        settle();
        tests++; if (pipe_hold !== 1'b0) begin fails++; $display("FAIL starve_release: got %b want 0", pipe_hold); end
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL starve_after_en: got %b want 0", rf_wr_en); end
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL starve_sb_clear: got %b want 0", sb_stall); end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        pipe_wr_en = 1'b1; pipe_w_addr = 5'd1; pipe_w_data = 32'h1111_1111;
        ll_valid = 1'b1; ll_addr = 5'd10; ll_data = 32'h0000_00A1;
        step();
        ll_addr = 5'd11; ll_data = 32'h0000_00A2;
        settle();
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL full_second_ready: got %b want 1", ll_ready); end
        step();
        ll_addr = 5'd12; ll_data = 32'h0000_00A3;
        settle();
        tests++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL full_ready_low: got %b want 0", ll_ready); end
        step();
        // pipe goes idle: head pops, but ready still reflects the pre-pop full state
        pipe_wr_en = 1'b0; pipe_w_addr = '0; pipe_w_data = '0;
        settle();
        tests++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL full_no_passthrough: got %b want 0", ll_ready); end
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd10 || rf_w_data !== 32'h0000_00A1) begin
            fails++; $display("FAIL full_pop1: got en=%b addr=%0d data=%h want en=1 addr=10 data=000000a1", rf_wr_en, rf_w_addr, rf_w_data);
        end
        step();
        settle();
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_pop: got %b want 1", ll_ready); end
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd11 || rf_w_data !== 32'h0000_00A2) begin
            fails++; $display("FAIL full_pop2: got en=%b addr=%0d data=%h want en=1 addr=11 data=000000a2", rf_wr_en, rf_w_addr, rf_w_data);
        end
        step();
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        settle();
        tests++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd12 || rf_w_data !== 32'h0000_00A3) begin
            fails++; $display("FAIL full_pop3: got en=%b addr=%0d data=%h want en=1 addr=12 data=000000a3", rf_wr_en, rf_w_addr, rf_w_data);
        end
        step();
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL full_drained: got %b want 0", rf_wr_en); end
        idle_inputs();
    endtask

    task automatic test_clk_en();
        clk_en = 1'b0;
        pipe_wr_en = 1'b1; pipe_w_addr = 5'd6; pipe_w_data = 32'h6666_6666;
        ll_issue = 1'b1; ll_issue_addr = 5'd13;
        ll_valid = 1'b1; ll_addr = 5'd13; ll_data = 32'h0000_000D;
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL clken_rf_wr_en: got %b want 0", rf_wr_en); end
        tests++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL clken_ll_ready: got %b want 0", ll_ready); end
        step();
        idle_inputs();
        clk_en = 1'b1;
        sb_rd_addr = 5'd13;
        settle();
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL clken_no_busy: got %b want 0", sb_stall); end
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL clken_no_queued: got %b want 0", rf_wr_en); end
        idle_inputs();
    endtask

    task automatic test_reset_flush();
        pipe_wr_en = 1'b1; pipe_w_addr = 5'd1; pipe_w_data = 32'h0000_0001;
        ll_issue = 1'b1; ll_issue_addr = 5'd3;
        ll_valid = 1'b1; ll_addr = 5'd3; ll_data = 32'h0000_0033;
        step();
        ll_issue_addr = 5'd4;
        ll_addr = 5'd4; ll_data = 32'h0000_0044;
        step();
        ll_issue = 1'b0; ll_valid = 1'b0;
        sb_rs_addr = 5'd3; sb_rt_addr = 5'd4;
        settle();
        tests++; if (ll_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full: got %b want 0", ll_ready); end
        tests++; if (sb_stall !== 1'b1) begin fails++; $display("FAIL flush_pre_busy: got %b want 1", sb_stall); end
        pipe_wr_en = 1'b0;
        reset = 1'b1;
        settle();
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL flush_in_reset: got %b want 0", rf_wr_en); end
        step();
        reset = 1'b0;
        settle();
        tests++; if (sb_stall !== 1'b0) begin fails++; $display("FAIL flush_busy_cleared: got %b want 0", sb_stall); end
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL flush_fifo_empty: got %b want 1", ll_ready); end
        tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL flush_no_write: got %b want 0", rf_wr_en); end
        step();
        settle();
        tests++; if (rf_wr_en !== 1'b0 || pipe_hold !== 1'b0) begin
            fails++; $display("FAIL flush_stays_idle: got en=%b hold=%b want en=0 hold=0", rf_wr_en, pipe_hold);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wb_passthrough();
        test_scoreboard();
        test_starvation();
        test_fifo_full();
        test_clk_en();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
